// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: streams operand bit pairs LSB first through one
// full-adder cell, keeping the carry in a flop between cycles.

module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

// state | meaning
// IDLE  | waiting for operands, in_ready high
// RUN   | one bit pair per cycle through the full adder
// DONE  | result presented, waiting for out_ready
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carryin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carryout,
  output logic             overflow
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sa, sb, ss;
  logic             c;
  logic [CW-1:0]    cnt;
  logic             fa_sum, fa_cout;
  logic             last_bit;

  full_adder u_fa (
    .a  (sa[0]),
    .b  (sb[0]),
    .ci (c),
    .s  (fa_sum),
    .co (fa_cout)
  );

  assign last_bit  = (cnt == CW'(WIDTH - 1));
  assign in_ready  = (state == IDLE) && rst_n;
  assign out_valid = (state == DONE);
  assign sum       = ss;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (in_valid) state_nxt = RUN;
      RUN:  if (last_bit) state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sa       <= '0;
      sb       <= '0;
      ss       <= '0;
      c        <= 1'b0;
      cnt      <= '0;
      carryout <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sa  <= a;
            sb  <= b;
            c   <= carryin;
            cnt <= '0;
          end
        end
        RUN: begin
          ss  <= {fa_sum, ss[WIDTH-1:1]};
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          c   <= fa_cout;
          cnt <= cnt + CW'(1);
          // c here is the carry into the MSB on the final bit
          if (last_bit) begin
            overflow <= c ^ fa_cout;
            carryout <= fa_cout;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
